// File: rtl/tqvp_dlmiles_i2c_pkg.sv
// Shared I2C definitions for the TinyQV I2C target and controller engines.
package tqvp_dlmiles_i2c_pkg;

  localparam int unsigned BITS_PER_BYTE = 8;
  localparam logic        I2C_ACK       = 1'b0;
  localparam logic        I2C_NACK      = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_LOAD,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_state_e;

  function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] own);
    return addr_byte[7:1] == own;
  endfunction

endpackage

// File: rtl/tqvp_dlmiles_i2c_target_if.sv
// Pad and host-side signal bundle of the I2C target engine.
interface tqvp_dlmiles_i2c_target_if;

  logic       scl_i;
  logic       sda_i;
  logic       scl_o;
  logic       scl_oe;
  logic       sda_o;
  logic       sda_oe;
  logic       enable;
  logic       stretch_en;
  logic [6:0] own_addr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ack;
  logic       evt_start;
  logic       evt_stop;
  logic       evt_nack;
  logic       evt_underrun;
  logic       rw;
  logic       busy;

  modport slave (
    input  scl_i, sda_i, enable, stretch_en, own_addr, tx_data, tx_valid,
    output scl_o, scl_oe, sda_o, sda_oe, rx_data, rx_valid, tx_ack,
           evt_start, evt_stop, evt_nack, evt_underrun, rw, busy
  );

  modport master (
    output scl_i, sda_i, enable, stretch_en, own_addr, tx_data, tx_valid,
    input  scl_o, scl_oe, sda_o, sda_oe, rx_data, rx_valid, tx_ack,
           evt_start, evt_stop, evt_nack, evt_underrun, rw, busy
  );

endinterface

// File: rtl/tqvp_dlmiles_i2c_sync.sv
// N-flop pad synchronizer with a previous-value register for edge detection.
module tqvp_dlmiles_i2c_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Reset to the idle-high bus level so reset release never fakes START/STOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '1;
      prev  <= 1'b1;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/tqvp_dlmiles_i2c_target.sv
// I2C target engine: START/STOP detect, 7-bit address match, write delivery, read serving.
module tqvp_dlmiles_i2c_target
  import tqvp_dlmiles_i2c_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                      clk,
  input logic                      rst_n,
  tqvp_dlmiles_i2c_target_if.slave bus
);

  localparam logic [3:0] CNT_FULL = 4'(BITS_PER_BYTE);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic       scl_oe_q, scl_oe_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_ack_q, tx_ack_d;
  logic       evt_start_q, evt_start_d;
  logic       evt_stop_q, evt_stop_d;
  logic       evt_nack_q, evt_nack_d;
  logic       evt_under_q, evt_under_d;

  tqvp_dlmiles_i2c_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.scl_i),
    .q    (scl_s),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  tqvp_dlmiles_i2c_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.sda_i),
    .q    (sda_s),
    .rise (sda_rise),
    .fall (sda_fall)
  );

  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      rx_data_q   <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      scl_oe_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_ack_q    <= 1'b0;
      evt_start_q <= 1'b0;
      evt_stop_q  <= 1'b0;
      evt_nack_q  <= 1'b0;
      evt_under_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      rx_data_q   <= rx_data_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      scl_oe_q    <= scl_oe_d;
      rx_valid_q  <= rx_valid_d;
      tx_ack_q    <= tx_ack_d;
      evt_start_q <= evt_start_d;
      evt_stop_q  <= evt_stop_d;
      evt_nack_q  <= evt_nack_d;
      evt_under_q <= evt_under_d;
    end
  end

  // Bits are counted on SCL rises, so the SCL fall that follows START is inert.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    rx_data_d   = rx_data_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    scl_oe_d    = 1'b0;
    rx_valid_d  = 1'b0;
    tx_ack_d    = 1'b0;
    evt_start_d = 1'b0;
    evt_stop_d  = 1'b0;
    evt_nack_d  = 1'b0;
    evt_under_d = 1'b0;

    if (!bus.enable) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else if (start_det) begin
      state_d     = ST_ADDR;
      cnt_d       = '0;
      sda_oe_d    = 1'b0;
      evt_start_d = 1'b1;
    end else if (stop_det) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      sda_oe_d   = 1'b0;
      evt_stop_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            sh_d  = {sh_q[6:0], sda_s};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == CNT_FULL) begin
            cnt_d = '0;
            if (addr_match(sh_q, bus.own_addr)) begin
              state_d  = ST_ADDR_ACK;
              sda_oe_d = !I2C_ACK;
              rw_d     = sh_q[0];
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = rw_q ? ST_RD_LOAD : ST_WR_BYTE;
          end
        end
        ST_WR_BYTE: begin
          if (scl_rise) begin
            sh_d  = {sh_q[6:0], sda_s};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == CNT_FULL) begin
            cnt_d      = '0;
            rx_data_d  = sh_q;
            rx_valid_d = 1'b1;
            sda_oe_d   = !I2C_ACK;
            state_d    = ST_WR_ACK;
          end
        end
        ST_WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = ST_WR_BYTE;
          end
        end
        ST_RD_LOAD: begin
          cnt_d = '0;
          if (bus.tx_valid) begin
            // Holding scl_oe one extra cycle gives bit7 setup before SCL is released.
            sh_d     = bus.tx_data;
            tx_ack_d = 1'b1;
            sda_oe_d = ~bus.tx_data[7];
            scl_oe_d = scl_oe_q;
            state_d  = ST_RD_BYTE;
          end else if (bus.stretch_en) begin
            scl_oe_d = 1'b1;
          end else begin
            sh_d        = 8'hFF;
            evt_under_d = 1'b1;
            sda_oe_d    = 1'b0;
            state_d     = ST_RD_BYTE;
          end
        end
        ST_RD_BYTE: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == CNT_FULL) begin
              cnt_d    = '0;
              sda_oe_d = 1'b0;
              state_d  = ST_RD_ACK;
            end else begin
              sh_d     = {sh_q[6:0], 1'b0};
              sda_oe_d = ~sh_q[6];
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise && sda_s == I2C_NACK) begin
            evt_nack_d = 1'b1;
            state_d    = ST_IGNORE;
          end else if (scl_fall) begin
            state_d = ST_RD_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.scl_o        = 1'b0;
  assign bus.sda_o        = 1'b0;
  assign bus.scl_oe       = scl_oe_q;
  assign bus.sda_oe       = sda_oe_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.tx_ack       = tx_ack_q;
  assign bus.evt_start    = evt_start_q;
  assign bus.evt_stop     = evt_stop_q;
  assign bus.evt_nack     = evt_nack_q;
  assign bus.evt_underrun = evt_under_q;
  assign bus.rw           = rw_q;
  assign bus.busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tqvp_dlmiles_i2c_target.sv
// Bit-banged I2C controller plus scoreboard exercising the I2C target engine.
module tb_tqvp_dlmiles_i2c_target;

  localparam int unsigned SYNC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tqvp_dlmiles_i2c_target_if bus();

  tqvp_dlmiles_i2c_target #(.SYNC_STAGES(SYNC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Open-drain wired-AND of the bench controller and the target.
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  assign bus.scl_i = m_scl & ~bus.scl_oe;
  assign bus.sda_i = m_sda & ~bus.sda_oe;

  int errors = 0;
  int checks = 0;
  int n_start = 0, n_stop = 0, n_nack = 0, n_under = 0, n_txack = 0;
  int e_start = 0, e_stop = 0, e_nack = 0, e_under = 0, e_txack = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] tx_q[$];
  logic [6:0] own;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: event tallies and write-data scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.evt_start)    n_start++;
      if (bus.evt_stop)     n_stop++;
      if (bus.evt_nack)     n_nack++;
      if (bus.evt_underrun) n_under++;
      if (bus.tx_ack)       n_txack++;
      if (bus.rx_valid) begin
        if (exp_rx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got byte 0x%0h, required no rx_valid", bus.rx_data);
        end else begin
          check("rx_data", int'(bus.rx_data), int'(exp_rx.pop_front()));
        end
      end
    end
  end

  // Host side of the read handshake: offer the head of tx_q, drop it when consumed.
  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.tx_ack && tx_q.size() > 0) void'(tx_q.pop_front());
      bus.tx_valid = (tx_q.size() > 0);
      bus.tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    end
  end

  task automatic wait_scl_high();
    int w = 0;
    while (w < 2000 && !bus.scl_i) begin
      @(negedge clk);
      w++;
    end
    if (!bus.scl_i) begin
      checks++;
      errors++;
      $display("FAIL scl_release: SCL low after %0d cycles, required high", w);
    end
  endtask

  task automatic clock_bit(input logic b, output logic r);
    m_sda = b;
    ticks(4);
    m_scl = 1'b1;
    wait_scl_high();
    ticks(4);
    r = bus.sda_i;
    ticks(4);
    m_scl = 1'b0;
    ticks(4);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    ticks(4);
    m_scl = 1'b1;
    wait_scl_high();
    ticks(4);
    m_sda = 1'b0;
    ticks(4);
    m_scl = 1'b0;
    ticks(4);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    ticks(4);
    m_scl = 1'b1;
    wait_scl_high();
    ticks(4);
    m_sda = 1'b1;
    ticks(8);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
    clock_bit(1'b1, r);
    acked = (r == 1'b0);
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] b);
    logic r;
    logic [7:0] v;
    v = '0;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, r);
      v[i] = r;
    end
    clock_bit(~ack, r);
    b = v;
  endtask

  task automatic check_counts();
    check("evt_start_count", n_start, e_start);
    check("evt_stop_count", n_stop, e_stop);
    check("evt_nack_count", n_nack, e_nack);
    check("evt_underrun_count", n_under, e_under);
    check("tx_ack_count", n_txack, e_txack);
    check("rx_pending", exp_rx.size(), 0);
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] data[$]);
    logic ack;
    bit match;
    match = (a == own);
    i2c_start();
    e_start++;
    send_byte({a, 1'b0}, ack);
    check("wr_addr_ack", ack, match);
    if (match) check("rw_write", bus.rw, 0);
    foreach (data[k]) begin
      if (match) exp_rx.push_back(data[k]);
      send_byte(data[k], ack);
      check("wr_data_ack", ack, match);
    end
    i2c_stop();
    e_stop++;
    ticks(2);
    check("busy_after_stop", bus.busy, 0);
    check_counts();
  endtask

  task automatic do_read(input logic [6:0] a, input logic [7:0] data[$], input bit supply);
    logic ack;
    logic [7:0] got;
    logic [7:0] want;
    bit match;
    match = (a == own);
    if (match && supply) foreach (data[k]) tx_q.push_back(data[k]);
    i2c_start();
    e_start++;
    send_byte({a, 1'b1}, ack);
    check("rd_addr_ack", ack, match);
    if (match) check("rw_read", bus.rw, 1);
    foreach (data[k]) begin
      want = (match && supply) ? data[k] : 8'hFF;
      recv_byte(k != data.size() - 1, got);
      check("rd_data", got, want);
    end
    i2c_stop();
    e_stop++;
    if (match) begin
      e_nack++;
      if (supply) e_txack += data.size();
      else        e_under += data.size();
    end
    ticks(2);
    check("busy_after_stop", bus.busy, 0);
    check_counts();
  endtask

  function automatic int out_vec();
    return int'({bus.rx_data, bus.rx_valid, bus.tx_ack, bus.evt_start, bus.evt_stop,
                 bus.evt_nack, bus.evt_underrun, bus.rw, bus.busy, bus.scl_oe,
                 bus.sda_oe, bus.scl_o, bus.sda_o});
  endfunction

  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] got;
    logic [7:0] addr_byte;
    logic [6:0] a;
    logic ack, r;
    int lat, lows, w, n;
    bit sup;

    own            = 7'h42;
    bus.own_addr   = own;
    bus.enable     = 1'b1;
    bus.stretch_en = 1'b0;
    ticks(4);
    check("reset_outputs", out_vec(), 0);
    rst_n = 1'b1;
    ticks(6);
    check("post_reset_outputs", out_vec(), 0);

    // Write 0xA5, 0x3C to own address.
    q.delete(); q.push_back(8'hA5); q.push_back(8'h3C);
    do_write(7'h42, q);

    // Foreign address: no ACK, no rx_valid.
    q.delete(); q.push_back(8'h11); q.push_back(8'h22);
    do_write(7'h43, q);

    // Read with bytes ready, ACK then NACK.
    q.delete(); q.push_back(8'h81); q.push_back(8'h7E);
    do_read(7'h42, q, 1'b1);

    // Read with clock stretching until the host supplies 0x55.
    bus.stretch_en = 1'b1;
    i2c_start();
    e_start++;
    send_byte({own, 1'b1}, ack);
    check("stretch_addr_ack", ack, 1);
    fork
      begin
        w = 0;
        while (w < 200 && !bus.scl_oe) begin
          @(negedge clk);
          w++;
        end
        check("stretch_seen", bus.scl_oe, 1);
        lows = 0;
        repeat (50) begin
          @(negedge clk);
          if (!bus.scl_oe) lows++;
        end
        check("stretch_hold", lows, 0);
        tx_q.push_back(8'h55);
      end
      begin
        recv_byte(1'b0, got);
        check("stretch_data", got, 8'h55);
      end
    join
    i2c_stop();
    e_stop++;
    e_txack++;
    e_nack++;
    ticks(2);
    check("stretch_released", bus.scl_oe, 0);
    check_counts();

    // Underrun: nothing ready and stretching disabled.
    bus.stretch_en = 1'b0;
    q.delete(); q.push_back(8'h00);
    do_read(7'h42, q, 1'b0);

    // Repeated START: write address, then read address.
    i2c_start();
    e_start++;
    send_byte({own, 1'b0}, ack);
    check("rs_wr_ack", ack, 1);
    check("rs_rw0", bus.rw, 0);
    tx_q.push_back(8'h5A);
    i2c_start();
    e_start++;
    send_byte({own, 1'b1}, ack);
    check("rs_rd_ack", ack, 1);
    check("rs_rw1", bus.rw, 1);
    recv_byte(1'b0, got);
    check("rs_data", got, 8'h5A);
    i2c_stop();
    e_stop++;
    e_txack++;
    e_nack++;
    ticks(2);
    check_counts();

    // Pad-to-SDA latency on the address ACK, then enable drop mid-transfer.
    i2c_start();
    e_start++;
    addr_byte = {own, 1'b0};
    for (int i = 7; i >= 1; i--) clock_bit(addr_byte[i], r);
    m_sda = addr_byte[0];
    ticks(4);
    m_scl = 1'b1;
    wait_scl_high();
    ticks(4);
    m_scl = 1'b0;
    lat = 0;
    while (lat < 20 && !bus.sda_oe) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("ack_latency", lat, SYNC + 1);
    ticks(2);
    bus.enable = 1'b0;
    ticks(2);
    check("disable_sda", bus.sda_oe, 0);
    check("disable_busy", bus.busy, 0);
    bus.enable = 1'b1;
    clock_bit(1'b1, r);
    i2c_stop();
    e_stop++;
    ticks(2);
    check_counts();

    // Asynchronous reset while the target is ACKing a read address.
    i2c_start();
    e_start++;
    addr_byte = {own, 1'b1};
    for (int i = 7; i >= 0; i--) clock_bit(addr_byte[i], r);
    check("pre_reset_ack", bus.sda_oe, 1);
    check("pre_reset_rw", bus.rw, 1);
    rst_n = 1'b0;
    #1;
    check("reset_mid_outputs", out_vec(), 0);
    check("reset_mid_sda", bus.sda_i, m_sda);
    m_sda = 1'b1;
    m_scl = 1'b1;
    ticks(4);
    rst_n = 1'b1;
    ticks(8);
    check("after_reset_busy", bus.busy, 0);
    check("after_reset_rx", bus.rx_data, 0);
    check_counts();

    // Randomized transfers against the rule-level model.
    for (int it = 0; it < 8; it++) begin
      own          = 7'($urandom_range(1, 126));
      bus.own_addr = own;
      a = ($urandom_range(0, 3) != 0) ? own : (own ^ 7'($urandom_range(1, 127)));
      n = $urandom_range(1, 3);
      q.delete();
      repeat (n) q.push_back(8'($urandom));
      if ($urandom_range(0, 1) != 0) begin
        do_write(a, q);
      end else begin
        sup = 1'($urandom_range(0, 1));
        bus.stretch_en = sup ? 1'($urandom_range(0, 1)) : 1'b0;
        do_read(a, q, sup);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
